// File: rtl/sgd_tx_scheduler.sv
// Round-robin TX scheduler: each grant emits one 512-bit beat {src, seq, payload} on AXI-stream.
// Define SGD_TX_BYTE_SWAP_EN to byte-reverse tdata so the header sits in network order at tdata[31:0].
module sgd_tx_scheduler #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned PAYLOAD_W = 480,
  parameter int unsigned SEQ_WRAP  = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_cfg_enable,
  input  logic [7:0]                   i_cfg_gap,
  input  logic [NUM_SRC-1:0]           i_s_valid,
  output logic [NUM_SRC-1:0]           o_s_ready,
  input  logic [NUM_SRC*PAYLOAD_W-1:0] i_s_payload,
  output logic                         o_m_axis_tx_data_tvalid,
  input  logic                         i_m_axis_tx_data_tready,
  output logic [511:0]                 o_m_axis_tx_data_tdata,
  output logic [63:0]                  o_m_axis_tx_data_tkeep,
  output logic                         o_m_axis_tx_data_tlast,
  output logic [31:0]                  o_stat_sent,
  output logic                         o_busy
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e       r_state;
  logic         r_tvalid;
  logic [511:0] r_tdata;
  logic [23:0]  r_seq;
  logic [2:0]   r_last_grant;
  logic [31:0]  r_stat_sent;
  logic [7:0]   r_gap_cnt;
  logic         r_busy;

  logic [7:0]           w_valid8;
  logic [2:0]           w_cand;
  logic [2:0]           w_grant;
  logic                 w_accept;
  logic [PAYLOAD_W-1:0] w_payload;
  logic [511:0]         w_word;
  logic [511:0]         w_beat;
  logic [23:0]          w_seq_next;

  assign w_valid8 = 8'(i_s_valid);
  assign w_accept = (r_state == StIdle) && i_cfg_enable && (|i_s_valid);

  // Scan downward so the closest source after last_grant is the final (winning) assignment.
  always_comb begin
    w_grant = r_last_grant;
    w_cand  = '0;
    for (int i = int'(NUM_SRC); i >= 1; i--) begin
      w_cand = 3'((int'(r_last_grant) + i) % int'(NUM_SRC));
      if (w_valid8[w_cand]) w_grant = w_cand;
    end
  end

  // Accept is a pure function of state and requester inputs, never of tready.
  always_comb begin
    o_s_ready = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (w_accept && (w_grant == 3'(i))) o_s_ready[i] = 1'b1;
    end
  end

  always_comb begin
    w_payload = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (w_grant == 3'(i)) w_payload = i_s_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  assign w_word     = {5'd0, w_grant, r_seq, w_payload};
  assign w_seq_next = (r_seq == 24'(SEQ_WRAP - 1)) ? 24'd0 : r_seq + 24'd1;

`ifdef SGD_TX_BYTE_SWAP_EN
  always_comb begin
    w_beat = '0;
    for (int i = 0; i < 64; i++) begin
      w_beat[i*8 +: 8] = w_word[511-i*8 -: 8];
    end
  end
`else
  assign w_beat = w_word;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_seq        <= '0;
      r_last_grant <= 3'(NUM_SRC - 1);
      r_stat_sent  <= '0;
      r_gap_cnt    <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_tdata      <= w_beat;
            r_tvalid     <= 1'b1;
            r_last_grant <= w_grant;
            r_busy       <= 1'b1;
            r_state      <= StSend;
          end
        end
        StSend: begin
          if (i_m_axis_tx_data_tready) begin
            r_tvalid    <= 1'b0;
            r_seq       <= w_seq_next;
            r_stat_sent <= r_stat_sent + 32'd1;
            if (i_cfg_gap == 8'd0) begin
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end else begin
              r_gap_cnt <= i_cfg_gap;
              r_state   <= StGap;
            end
          end
        end
        StGap: begin
          r_gap_cnt <= r_gap_cnt - 8'd1;
          if (r_gap_cnt == 8'd1) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_m_axis_tx_data_tvalid = r_tvalid;
  assign o_m_axis_tx_data_tdata  = r_tdata;
  assign o_m_axis_tx_data_tkeep  = 64'hFFFF_FFFF_FFFF_FFFF;
  assign o_m_axis_tx_data_tlast  = 1'b1;
  assign o_stat_sent             = r_stat_sent;
  assign o_busy                  = r_busy;

endmodule

// File: doc/sgd_tx_scheduler.md
# sgd_tx_scheduler

Round-robin transmit scheduler that shares the single 512-bit network TX AXI-stream between up to eight SGD result producers (dot-product senders, gradient/model pushers). Each accepted payload goes out as one stamped beat: a 32-bit header carrying source ID and sequence number, followed by the payload. The block honours `m_axis_tx_data.ready` back-pressure and holds its output stable while stalled. An optional programmable inter-packet gap paces traffic toward the switch.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesters, legal 2..8.
- `PAYLOAD_W`, 480: payload width per requester; header + payload = 512.
- `SEQ_WRAP`, 128: sequence counter modulus, legal 2..2^24.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: synchronous reset, active-low.
- `cfg_enable`, in, 1: permits new grants.
- `cfg_gap`, in, 8: idle cycles inserted after each handshake; sampled at handshake.
- `s_valid`, in, NUM_SRC: per-source payload valid.
- `s_ready`, out, NUM_SRC: per-source accept, at most one bit high (one-hot or zero).
- `s_payload`, in, NUM_SRC×PAYLOAD_W: per-source payload.
- `m_axis_tx_data`, axi_stream.master, 512-bit data: network TX stream; keep and last driven.
- `stat_sent`, out, 32: count of completed TX handshakes, wraps at 2^32.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE
  - If `cfg_enable` and `|s_valid`: grant the first valid source searching upward from `last_grant+1`, modulo NUM_SRC.
  - `s_ready[g]=1` combinationally in that cycle; the transfer completes that cycle.
  - Capture the beat, set `last_grant=g`, go to SEND.
- SEND
  - `valid=1`; data held stable until `ready`.
  - On handshake: `seq=(seq+1)%SEQ_WRAP`, `stat_sent++`.
  - If sampled `cfg_gap==0`, go to IDLE; else load `gap_cnt=cfg_gap` and go to GAP.
- GAP
  - Decrement `gap_cnt`; at `gap_cnt==1`, go to IDLE.
  - `s_ready=0` throughout.
- Beat assembly: `word[511:504]=g` (zero-extended), `word[503:480]=seq` (zero-extended), `word[479:0]=s_payload[g]`. `keep=64'hFFFF_FFFF_FFFF_FFFF`, `last=1`.
- Deasserting `cfg_enable` blocks new grants only. A beat already in SEND completes, and GAP runs to completion.
- `s_ready` never depends combinationally on `m_axis_tx_data.ready`.
- Reset values: state IDLE, `valid=0`, data 0, `seq=0`, `last_grant=NUM_SRC-1` (source 0 wins first), `stat_sent=0`, `s_ready=0`, `busy=0`, `gap_cnt=0`.
- Reset during SEND or GAP drops the pending beat. `valid` is 0 in the cycle after rst_n is sampled low.

## Timing
- Accept at cycle t → `m_axis_tx_data.valid=1` at t+1.
- Peak throughput: one beat per 2 cycles (IDLE↔SEND) with `cfg_gap=0` and ready high.
- Beat spacing with `cfg_gap=G>0` and ready high: G+2 cycles.
- Stall: while `valid & ~ready`, data, seq and `stat_sent` are frozen and no source is granted.
- Fairness: with all sources continuously valid, each source is granted exactly once per NUM_SRC grants.

## Configuration
- `SGD_TX_BYTE_SWAP_EN` defined: the output byte order is reversed relative to the assembled word, so `tdata[i*8+7:i*8] = word[511-i*8 -: 8]`. This puts the header in network order at the lowest bytes; `tdata[7:0]` is the source ID.
- Not defined: `tdata = word` unmodified.

## Test plan
- Source 0 only, payload `480'h1`, ready=1, gap=0, macro off → tdata=`{8'h00,24'h0,480'h1}` one cycle after accept; next beat carries seq 1; `stat_sent=2`.
- All 4 sources continuously valid, gap=0 → grant order 0,1,2,3,0,1; a new valid beat every 2 cycles.
- ready low for 10 cycles during SEND → tdata unchanged, `s_ready=0`, seq/`stat_sent` unchanged; beat completes in the first ready cycle.
- `cfg_gap=3`, source 1 continuously valid → handshakes spaced 5 cycles apart; `s_ready[1]` is low during the 3 GAP cycles.
- 130 single-source beats, `SEQ_WRAP=128` → seq runs …126,127,0,1; `stat_sent=130`; then reset asserted mid-SEND → valid 0 next cycle, seq 0, and the next grant goes to source 0.
- Macro defined, source 2, seq 5 → `tdata[7:0]=8'h02`, `tdata[31:8]={8'h05,8'h00,8'h00}`, `tdata[511:504]` = payload byte [7:0].
